// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback/retire arbiter: instruction field
// slices, control-flow opcodes and the per-channel FIFO entry.
package wb_pkg;

  // Widest datapath an entry can carry; narrower builds use the low bits.
  localparam int ENTRY_XLEN = 64;

  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] res;
    logic [31:0]           ir;
    logic                  reg_wen;
    logic                  w;
    logic                  pc_mux;
    logic [ENTRY_XLEN-1:0] target;
  } wb_entry_t;

  function automatic logic is_ctrl_flow(input logic [31:0] ir);
    case (ir[6:2])
      OP_BRANCH, OP_JALR, OP_JAL: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO: circular buffer with an occupancy count, plus a
// per-entry control-flow flag so the stage can report pending branches.
module wb_chan_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t pop_data,
  output logic      full,
  output logic      empty,
  output logic      cf_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] cf;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem[rd_ptr];
  assign cf_pending = |(valid & cf);

  // NOTE: payload storage has no reset; valid/count below decide what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      cf     <= '0;
    end else begin
      if (do_push) begin
        wr_ptr        <= next_ptr(wr_ptr);
        valid[wr_ptr] <= 1'b1;
        cf[wr_ptr]    <= is_ctrl_flow(push_data.ir);
      end
      if (do_pop) begin
        rd_ptr        <= next_ptr(rd_ptr);
        valid[rd_ptr] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_retire_arbiter.sv
// Writeback stage: NUM_CH result FIFOs served round-robin into one registered
// RF write port and redirect port. XLEN must lie in 33..64.
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module wb_retire_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_CH-1:0]      IN_V,
  output logic [NUM_CH-1:0]      IN_RDY,
  input  logic [NUM_CH*XLEN-1:0] IN_RES,
  input  logic [NUM_CH*32-1:0]   IN_IR,
  input  logic [NUM_CH-1:0]      IN_REG_WEN,
  input  logic [NUM_CH-1:0]      IN_W,
  input  logic [NUM_CH-1:0]      IN_PC_MUX,
  input  logic [NUM_CH*XLEN-1:0] IN_TARGET,
  output logic                   OUT_DE_REG_WEN,
  output logic [4:0]             OUT_DE_DR,
  output logic [XLEN-1:0]        OUT_DE_Data,
  output logic                   OUT_FE_PC_MUX,
  output logic [XLEN-1:0]        OUT_FE_Target_Address,
  output logic                   V_OUT_FE_BR_STALL,
  output logic [63:0]            OUT_RETIRE_CNT
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  wb_entry_t [NUM_CH-1:0] pop_data;
  logic [NUM_CH-1:0]      full;
  logic [NUM_CH-1:0]      empty;
  logic [NUM_CH-1:0]      cf_pending;
  logic [NUM_CH-1:0]      pop;
  logic                   rdy_en;
  logic [CHW-1:0]         rr_ptr;
  logic [CHW-1:0]         grant_idx;
  logic                   grant_valid;
  int                     cand;
  wb_entry_t              win;
  logic [XLEN-1:0]        win_res;
  logic [4:0]             win_rd;
  logic                   out_cf;

  // Ready is held low until the first edge after reset release.
  assign IN_RDY = ~full & {NUM_CH{rdy_en}};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    wb_entry_t ch_in;

    always_comb begin
      ch_in             = '0;
      ch_in.res[XLEN-1:0]    = IN_RES[ch*XLEN +: XLEN];
      ch_in.ir               = IN_IR[ch*32 +: 32];
      ch_in.reg_wen          = IN_REG_WEN[ch];
      ch_in.w                = IN_W[ch];
      ch_in.pc_mux           = IN_PC_MUX[ch];
      ch_in.target[XLEN-1:0] = IN_TARGET[ch*XLEN +: XLEN];
    end

    wb_chan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (IN_V[ch] && IN_RDY[ch]),
      .push_data (ch_in),
      .pop       (pop[ch]),
      .pop_data  (pop_data[ch]),
      .full      (full[ch]),
      .empty     (empty[ch]),
      .cf_pending(cf_pending[ch])
    );
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    pop         = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_CH;
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = CHW'(cand);
      end
    end
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  assign win     = pop_data[grant_idx];
  assign win_res = win.res[XLEN-1:0];
  assign win_rd  = win.ir[RD_MSB:RD_LSB];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en                <= 1'b0;
      rr_ptr                <= CHW'(NUM_CH - 1);
      OUT_DE_REG_WEN        <= 1'b0;
      OUT_DE_DR             <= '0;
      OUT_DE_Data           <= '0;
      OUT_FE_PC_MUX         <= 1'b0;
      OUT_FE_Target_Address <= '0;
      out_cf                <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (grant_valid) begin
        rr_ptr         <= grant_idx;
        OUT_DE_REG_WEN <= win.reg_wen && (win_rd != 5'd0);
        OUT_DE_DR      <= win_rd;
        OUT_DE_Data    <= win.w ? {{(XLEN-32){win_res[31]}}, win_res[31:0]} : win_res;
        OUT_FE_PC_MUX  <= win.pc_mux;
        if (win.pc_mux) OUT_FE_Target_Address <= win.target[XLEN-1:0];
        out_cf         <= is_ctrl_flow(win.ir);
      end else begin
        OUT_DE_REG_WEN <= 1'b0;
        OUT_DE_DR      <= '0;
        OUT_DE_Data    <= '0;
        OUT_FE_PC_MUX  <= 1'b0;
        out_cf         <= 1'b0;
      end
    end
  end

  assign V_OUT_FE_BR_STALL = out_cf || (|cf_pending);

`ifdef RETIRE_CNT_EN
  logic [63:0] retire_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           retire_cnt <= '0;
    else if (grant_valid) retire_cnt <= retire_cnt + 64'd1;
  end

  assign OUT_RETIRE_CNT = retire_cnt;
`else
  assign OUT_RETIRE_CNT = '0;
`endif

endmodule

// File: tb/tb_wb_retire_arbiter.sv
// Self-checking bench for wb_retire_arbiter (NUM_CH=2, FIFO_DEPTH=2, XLEN=64):
// directed steps plus random traffic against a queue-based reference model.
module tb_wb_retire_arbiter;

  localparam int XLEN  = 64;
  localparam int NCH   = 2;
  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] res;
    logic [31:0] ir;
    bit          wen;
    bit          w;
    bit          pcm;
    logic [63:0] tgt;
  } ref_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      in_v;
  logic [NCH-1:0]      in_rdy;
  logic [NCH*XLEN-1:0] in_res;
  logic [NCH*32-1:0]   in_ir;
  logic [NCH-1:0]      in_reg_wen;
  logic [NCH-1:0]      in_w;
  logic [NCH-1:0]      in_pc_mux;
  logic [NCH*XLEN-1:0] in_target;
  logic                out_wen;
  logic [4:0]          out_dr;
  logic [XLEN-1:0]     out_data;
  logic                out_pcm;
  logic [XLEN-1:0]     out_tgt;
  logic                br_stall;
  logic [63:0]         retire_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  ref_t        q[NCH][$];
  int          rr_m;
  bit          rdy_en_m;
  bit          exp_wen;
  logic [4:0]  exp_dr;
  logic [63:0] exp_data;
  bit          exp_pcm;
  logic [63:0] exp_tgt;
  bit          exp_out_cf;
  logic [63:0] exp_cnt;

  wb_retire_arbiter #(.XLEN(XLEN), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .CLK                  (clk),
    .RST_N                (rst_n),
    .IN_V                 (in_v),
    .IN_RDY               (in_rdy),
    .IN_RES               (in_res),
    .IN_IR                (in_ir),
    .IN_REG_WEN           (in_reg_wen),
    .IN_W                 (in_w),
    .IN_PC_MUX            (in_pc_mux),
    .IN_TARGET            (in_target),
    .OUT_DE_REG_WEN       (out_wen),
    .OUT_DE_DR            (out_dr),
    .OUT_DE_Data          (out_data),
    .OUT_FE_PC_MUX        (out_pcm),
    .OUT_FE_Target_Address(out_tgt),
    .V_OUT_FE_BR_STALL    (br_stall),
    .OUT_RETIRE_CNT       (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit is_cf(input logic [31:0] ir);
    return ir[6:2] inside {5'b11000, 5'b11001, 5'b11011};
  endfunction

  function automatic logic [63:0] cnt_exp();
`ifdef RETIRE_CNT_EN
    return exp_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) q[c].delete();
    rr_m       = NCH - 1;
    rdy_en_m   = 1'b0;
    exp_wen    = 1'b0;
    exp_dr     = '0;
    exp_data   = '0;
    exp_pcm    = 1'b0;
    exp_tgt    = '0;
    exp_out_cf = 1'b0;
    exp_cnt    = '0;
  endtask

  task automatic drive_ch(input int c, input bit v, input logic [63:0] res, input logic [31:0] ir,
                          input bit wen, input bit w, input bit pcm, input logic [63:0] tgt);
    in_v[c]                  = v;
    in_res[c*XLEN +: XLEN]   = res;
    in_ir[c*32 +: 32]        = ir;
    in_reg_wen[c]            = wen;
    in_w[c]                  = w;
    in_pc_mux[c]             = pcm;
    in_target[c*XLEN +: XLEN] = tgt;
  endtask

  task automatic rand_ch(input int c, input bit v);
    logic [4:0]  ops [5] = '{5'b11000, 5'b11001, 5'b11011, 5'b01100, 5'b00100};
    logic [31:0] ir;
    ir      = $urandom;
    ir[6:2] = ops[$urandom_range(0, 4)];
    ir[1:0] = 2'b11;
    drive_ch(c, v, {$urandom, $urandom}, ir, 1'($urandom), 1'($urandom), 1'($urandom),
             {$urandom, $urandom});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, 64'(out_wen), 64'd0);
    check({tag, "_dr"}, 64'(out_dr), 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_pcm"}, 64'(out_pcm), 64'd0);
    check({tag, "_tgt"}, out_tgt, 64'd0);
    check({tag, "_stall"}, 64'(br_stall), 64'd0);
    check({tag, "_rdy"}, 64'(in_rdy), 64'd0);
    check({tag, "_cnt"}, retire_cnt, 64'd0);
  endtask

  // One clock: check pre-edge signals, advance the model, clock, check outputs.
  task automatic cycle();
    logic [NCH-1:0] rdy_m;
    bit             stall_m;
    bit             popped;
    int             cc;
    ref_t           e;
    ref_t           n;
    for (int c = 0; c < NCH; c++) rdy_m[c] = rdy_en_m && (q[c].size() < DEPTH);
    stall_m = exp_out_cf;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < q[c].size(); k++)
        if (is_cf(q[c][k].ir)) stall_m = 1'b1;
    check("in_rdy", 64'(in_rdy), 64'(rdy_m));
    check("br_stall", 64'(br_stall), 64'(stall_m));

    popped = 1'b0;
    e      = '{default: '0};
    for (int i = 1; i <= NCH; i++) begin
      cc = (rr_m + i) % NCH;
      if (!popped && q[cc].size() > 0) begin
        popped = 1'b1;
        e      = q[cc].pop_front();
        rr_m   = cc;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (in_v[c] && rdy_m[c]) begin
        n.res = in_res[c*XLEN +: XLEN];
        n.ir  = in_ir[c*32 +: 32];
        n.wen = in_reg_wen[c];
        n.w   = in_w[c];
        n.pcm = in_pc_mux[c];
        n.tgt = in_target[c*XLEN +: XLEN];
        q[c].push_back(n);
      end
    end
    if (popped) begin
      exp_wen    = e.wen && (e.ir[11:7] != 5'd0);
      exp_dr     = e.ir[11:7];
      exp_data   = e.w ? 64'(signed'(e.res[31:0])) : e.res;
      exp_pcm    = e.pcm;
      if (e.pcm) exp_tgt = e.tgt;
      exp_out_cf = is_cf(e.ir);
      exp_cnt    = exp_cnt + 64'd1;
    end else begin
      exp_wen    = 1'b0;
      exp_dr     = '0;
      exp_data   = '0;
      exp_pcm    = 1'b0;
      exp_out_cf = 1'b0;
    end

    @(posedge clk);
    rdy_en_m = 1'b1;
    @(negedge clk);
    check("de_wen", 64'(out_wen), 64'(exp_wen));
    check("de_dr", 64'(out_dr), 64'(exp_dr));
    check("de_data", out_data, exp_data);
    check("fe_pcm", 64'(out_pcm), 64'(exp_pcm));
    check("fe_tgt", out_tgt, exp_tgt);
    check("retire_cnt", retire_cnt, cnt_exp());
  endtask

  initial begin
    // Reset held with all channels offering data: nothing may be accepted.
    rst_n = 1'b0;
    reset_model();
    for (int c = 0; c < NCH; c++) rand_ch(c, 1'b1);
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    in_v  = '0;
    rst_n = 1'b1;
    cycle();                         // ready still low before the first edge
    check("rdy_after_release", 64'(in_rdy), 64'h3);

    // Single W-op push on ch0, rd=5: visible two edges later, sign-extended.
    drive_ch(0, 1'b1, 64'h1_8000_0000, {20'h0, 5'd5, 7'b0110011}, 1'b1, 1'b1, 1'b0, 64'h0);
    cycle();
    in_v = '0;
    cycle();
    check("single_wen", 64'(out_wen), 64'd1);
    check("single_dr", 64'(out_dr), 64'd5);
    check("single_data", out_data, 64'hFFFF_FFFF_8000_0000);
    cycle();

    // Write to x0 is suppressed.
    drive_ch(1, 1'b1, 64'h1234, {20'h0, 5'd0, 7'b0110011}, 1'b1, 1'b0, 1'b0, 64'h0);
    cycle();
    in_v = '0;
    cycle();
    check("x0_wen", 64'(out_wen), 64'd0);
    cycle();

    // JAL redirect: single-cycle pulse, target kept, stall spans push..output.
    drive_ch(0, 1'b1, 64'h8, {20'h0, 5'd1, 7'b1101111}, 1'b1, 1'b0, 1'b1, 64'h400);
    cycle();
    in_v = '0;
    check("jal_stall_queued", 64'(br_stall), 64'd1);
    cycle();
    check("jal_pcm", 64'(out_pcm), 64'd1);
    check("jal_tgt", out_tgt, 64'h400);
    check("jal_stall_out", 64'(br_stall), 64'd1);
    cycle();
    check("jal_pcm_pulse", 64'(out_pcm), 64'd0);
    check("jal_tgt_hold", out_tgt, 64'h400);
    check("jal_stall_clear", 64'(br_stall), 64'd0);

    // Both channels saturated: FIFOs fill, ready drops, grants alternate.
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < NCH; c++) rand_ch(c, 1'b1);
      cycle();
    end
    in_v = '0;
    repeat (6) cycle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < NCH; c++) rand_ch(c, 1'($urandom_range(0, 3) != 0));
      cycle();
    end
    in_v = '0;
    repeat (6) cycle();

    // Three entries queued, then asynchronous reset mid-cycle.
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) rand_ch(c, 1'b1);
      cycle();
    end
    in_v = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    reset_model();
    @(negedge clk);
    check_all_zero("midreset_held");
    rst_n = 1'b1;
    repeat (5) cycle();

    // Ten pops after the reset: counter (when built in) reads 10.
    for (int i = 0; i < 10; i++) begin
      rand_ch(0, 1'b1);
      in_v[1] = 1'b0;
      cycle();
    end
    in_v = '0;
    repeat (3) cycle();
    check("retire_cnt_10", retire_cnt, cnt_exp());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
